axi_lite_reg_slave: RTL
=======================

# axi_lite_reg_slave

AXI-Lite slave register bank: the downstream endpoint for the AXI-Lite master in the interconnect examples. Accepts write address/data in either order, commits byte-strobed writes to a small word-addressed register file, and answers reads with registered data. Exposes the writable registers and per-register write pulses to local logic. The top register is a read-only status word driven by that logic.

## Interface
- ADDR_WIDTH, 4, byte address width; NUM_REGS = 2**(ADDR_WIDTH-2) words
- DATA_WIDTH, 32, register and bus data width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- RESET_VAL, 0, reset value of every writable register

- clk_i  input  1  clock, all logic on rising edge
- rstn_i  input  1  synchronous, active-low reset
- axil  interface (AXI_LITE, slave side)  -  aw*, w*, b*, ar*, r* channels; awprot/arprot ignored
- status_i  input  DATA_WIDTH  value returned for register NUM_REGS-1
- regs_o  output  (NUM_REGS-1)*DATA_WIDTH  writable registers, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse_o  output  NUM_REGS-1  one-cycle pulse per register on commit

## Operation
- Index = addr[ADDR_WIDTH-1:2]; regs 0..NUM_REGS-2 read/write, reg NUM_REGS-1 read-only (status_i).
- Write path: AW and W captured independently into holding registers (aw_held, w_held); either order, or same cycle.
- awready = !aw_held && !bvalid && !in_reset; wready likewise with w_held. Both registered.
- Commit when aw_held && w_held: bytes with wstrb[i]=1 updated, others kept; wr_pulse_o[idx]=1 for that cycle; bvalid=1, bresp=OKAY (2'b00).
- bvalid holds until bready; on B handshake aw_held, w_held cleared, awready/wready reassert next cycle.
- Write to reg NUM_REGS-1: no register change, no pulse; response per Configuration.
- wstrb=0: commit with no data change, pulse still asserted, OKAY.
- Read path: arready high when no read outstanding. On AR handshake rdata loaded from indexed register (status_i sampled for top reg), rvalid=1, rresp=OKAY, arready=0.
- rvalid/rdata/rresp held stable until rready; on R handshake rvalid=0, arready=1 next cycle.
- Read and write fully independent; may overlap in any cycle.

## Timing
- Reset (rstn_i=0 at an edge): awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; registers = RESET_VAL; wr_pulse_o = 0; held flags cleared. Readies rise the first cycle after reset release.
- Write latency: bvalid and register update at edge after the later of AW/W handshakes (same-cycle AW+W: one cycle).
- Read latency: rvalid high the cycle after AR handshake.
- Read/write same register, AR handshake at the commit edge: rdata returns pre-commit value.
- Back-to-back write: min 3 cycles per write (handshake, commit/bvalid, bready); next AW accepted the cycle after B handshake.
- Reset mid-transaction: outstanding B/R discarded, held AW/W dropped, no commit.
- No combinational path from any input to any output.

## Configuration
- AXIL_REG_SLVERR_EN defined: write to reg NUM_REGS-1 returns bresp=SLVERR (2'b10); any access with addr[1:0]!=0 returns SLVERR (write: no change, no pulse; read: rdata=0).
- Undefined: all responses OKAY; read-only writes silently dropped; addr[1:0] ignored.

## Test plan
- Reset, then AW addr 0x4 + W 0xDEADBEEF strb 4'hF same cycle -> bvalid one cycle later, bresp 0, regs_o reg1 = 0xDEADBEEF, wr_pulse_o[1] one cycle.
- W 0x000000AA strb 4'h1 three cycles before AW addr 0x0 (reg0 = 0x12345678) -> reg0 = 0x123456AA, B only after AW accepted.
- status_i=0xCAFEF00D, AR addr 0xC with rready low 5 cycles -> rvalid held, rdata stable 0xCAFEF00D, arready low until R handshake.
- Write 0x11111111 to 0xC -> status read still 0xCAFEF00D, no pulse; bresp 2'b10 with AXIL_REG_SLVERR_EN, 2'b00 without.
- AR addr 0x8 at same edge as commit of 0x55 to 0x8 (old 0x0) -> rdata 0x0; following read 0x55.
- rstn_i low while bvalid and rvalid high -> both 0 next cycle, registers RESET_VAL, readies high one cycle after release.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI-Lite slave register bank. Write address and write data are captured
// independently (either order or same cycle) and committed with byte strobes
// into a small word-addressed register file. Reads return registered data. The
// top word (index NUM_REGS-1) is a read-only status word supplied by local
// logic. Every output is driven straight from a flop.
//
// Optional feature macro: AXIL_REG_SLVERR_EN
//   defined   : writes to the status word and any access with addr[1:0] != 0
//               answer SLVERR; misaligned writes are dropped, misaligned
//               reads return zero.
//   undefined : all responses OKAY, status writes silently dropped,
//               addr[1:0] ignored.
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       synchronous active-low reset
//   axil_aw*     write address channel (awprot ignored)
//   axil_w*      write data channel
//   axil_b*      write response channel
//   axil_ar*     read address channel (arprot ignored)
//   axil_r*      read data channel
//   status_i     value returned for register NUM_REGS-1
//   regs_o       writable registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_o   one-cycle pulse per writable register on commit
// -----------------------------------------------------------------------------
module axi_lite_reg_slave #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned NUM_REGS = 2 ** (ADDR_WIDTH - 2)
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  logic [ADDR_WIDTH-1:0]                axil_awaddr,
   input  logic [2:0]                           axil_awprot,
   input  logic                                 axil_awvalid,
   output logic                                 axil_awready,
   input  logic [DATA_WIDTH-1:0]                axil_wdata,
   input  logic [STRB_WIDTH-1:0]                axil_wstrb,
   input  logic                                 axil_wvalid,
   output logic                                 axil_wready,
   output logic [1:0]                           axil_bresp,
   output logic                                 axil_bvalid,
   input  logic                                 axil_bready,
   input  logic [ADDR_WIDTH-1:0]                axil_araddr,
   input  logic [2:0]                           axil_arprot,
   input  logic                                 axil_arvalid,
   output logic                                 axil_arready,
   output logic [DATA_WIDTH-1:0]                axil_rdata,
   output logic [1:0]                           axil_rresp,
   output logic                                 axil_rvalid,
   input  logic                                 axil_rready,
   input  logic [DATA_WIDTH-1:0]                status_i,
   output logic [(NUM_REGS-1)*DATA_WIDTH-1:0]   regs_o,
   output logic [NUM_REGS-2:0]                  wr_pulse_o
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // State
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
   logic                  aw_held_q, w_held_q;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic                  awready_q, wready_q, arready_q;
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [NUM_REGS-2:0]   wr_pulse_q;
`ifdef AXIL_REG_SLVERR_EN
   logic                  aw_mis_q;
`endif

   // Next-state decode
   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
   logic                  aw_held_n, w_held_n, bvalid_n, rvalid_n;
   logic                  wr_err, wr_drop, rd_err;
   logic [DATA_WIDTH-1:0] rd_data;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      aw_hs     = axil_awvalid && awready_q;
      w_hs      = axil_wvalid  && wready_q;
      b_hs      = bvalid_q     && axil_bready;
      ar_hs     = axil_arvalid && arready_q;
      r_hs      = rvalid_q     && axil_rready;
      // Held flags stay up until the B handshake, so !bvalid_q keeps the
      // commit to a single cycle.
      commit    = aw_held_q && w_held_q && !bvalid_q;
      aw_held_n = aw_hs || (aw_held_q && !b_hs);
      w_held_n  = w_hs  || (w_held_q  && !b_hs);
      bvalid_n  = commit || (bvalid_q && !b_hs);
      rvalid_n  = ar_hs  || (rvalid_q && !r_hs);

      wr_err  = 1'b0;
      wr_drop = (aw_idx_q == TOP_IDX);
      rd_err  = 1'b0;
      rd_data = status_i;
      for (int k = 0; k < NUM_REGS - 1; k++) begin
         if (axil_araddr[ADDR_WIDTH-1:2] == IDX_W'(k)) rd_data = regs_q[k];
      end
`ifdef AXIL_REG_SLVERR_EN
      wr_err  = (aw_idx_q == TOP_IDX) || aw_mis_q;
      wr_drop = wr_err;
      if (axil_araddr[1:0] != 2'b00) begin
         rd_err  = 1'b1;
         rd_data = '0;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         // NOTE: the register file is a handful of flops visible on regs_o, so
         // it is reset like control state rather than left as uninitialised RAM.
         for (int k = 0; k < NUM_REGS - 1; k++) regs_q[k] <= RESET_VAL;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_idx_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         arready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
`ifdef AXIL_REG_SLVERR_EN
         aw_mis_q   <= 1'b0;
`endif
      end else begin
         wr_pulse_q <= '0;
         aw_held_q  <= aw_held_n;
         w_held_q   <= w_held_n;
         bvalid_q   <= bvalid_n;
         rvalid_q   <= rvalid_n;
         // Readies are registered copies of next-cycle availability.
         awready_q  <= !aw_held_n && !bvalid_n;
         wready_q   <= !w_held_n  && !bvalid_n;
         arready_q  <= !rvalid_n;

         if (aw_hs) begin
            aw_idx_q <= axil_awaddr[ADDR_WIDTH-1:2];
`ifdef AXIL_REG_SLVERR_EN
            aw_mis_q <= (axil_awaddr[1:0] != 2'b00);
`endif
         end
         if (w_hs) begin
            w_data_q <= axil_wdata;
            w_strb_q <= axil_wstrb;
         end

         if (commit) begin
            bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            for (int k = 0; k < NUM_REGS - 1; k++) begin
               if (!wr_drop && aw_idx_q == IDX_W'(k)) begin
                  wr_pulse_q[k] <= 1'b1;
                  for (int b = 0; b < STRB_WIDTH; b++) begin
                     if (w_strb_q[b]) regs_q[k][b*8 +: 8] <= w_data_q[b*8 +: 8];
                  end
               end
            end
         end

         if (ar_hs) begin
            rdata_q <= rd_data;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // Outputs
   assign axil_awready = awready_q;
   assign axil_wready  = wready_q;
   assign axil_arready = arready_q;
   assign axil_bvalid  = bvalid_q;
   assign axil_bresp   = bresp_q;
   assign axil_rvalid  = rvalid_q;
   assign axil_rresp   = rresp_q;
   assign axil_rdata   = rdata_q;
   assign wr_pulse_o   = wr_pulse_q;

   for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_regs_o
      assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   // Protection bits are ignored; the byte offset is only decoded when the
   // SLVERR feature is built in.
   logic unused_bits;
   assign unused_bits = ^{axil_awprot, axil_arprot, axil_awaddr[1:0], axil_araddr[1:0]};

endmodule
